// File: rtl/bp_common_pkg.sv
// Shared types for the co-simulation scheduler: run-sequencing states and a saturating increment.
package bp_common_pkg;

   typedef enum logic [1:0] {e_init, e_run, e_drain, e_done} bp_cosim_sched_state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/bp_nonsynth_cosim_rr_arb.sv
// Round-robin grant over pre-masked requests; the grant is held while the checker stalls.
module bp_nonsynth_cosim_rr_arb #(
   parameter int unsigned num_core_p = 4,
   localparam int unsigned id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [num_core_p-1:0]  v_i,
   input  logic                   ready_i,
   output logic                   v_o,
   output logic [id_width_lp-1:0] grant_id_o,
   output logic [num_core_p-1:0]  yumi_o
);

   logic [id_width_lp-1:0] rr_q, rr_d;
   logic [id_width_lp-1:0] held_q;
   logic                   stall_q;
   logic                   found;
   int unsigned            idx;

   always_comb begin
      grant_id_o = '0;
      found      = 1'b0;
      idx        = 0;
      for (int unsigned i = 0; i < num_core_p; i++) begin
         idx = (int'(rr_q) + i) % num_core_p;
         if (!found && v_i[idx]) begin
            found      = 1'b1;
            grant_id_o = id_width_lp'(idx);
         end
      end
      // A stalled grant stays put so the checker sees a stable record.
      if (stall_q && v_i[held_q]) begin
         grant_id_o = held_q;
      end
      v_o    = |v_i;
      yumi_o = '0;
      rr_d   = rr_q;
      if (v_o && ready_i) begin
         yumi_o[grant_id_o] = 1'b1;
         rr_d = (grant_id_o == id_width_lp'(num_core_p - 1)) ? '0 : grant_id_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_q    <= '0;
         held_q  <= '0;
         stall_q <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         held_q  <= grant_id_o;
         stall_q <= v_o & ~ready_i;
      end
   end

endmodule

// File: rtl/bp_nonsynth_cosim_sched.sv
// Serializes per-core commit records into one checker port and sequences init/run/drain/done.
// Optional stall watchdog enabled by defining BP_COSIM_SCHED_WATCHDOG_EN.
module bp_nonsynth_cosim_sched
   import bp_common_pkg::*;
#(
   parameter int unsigned num_core_p    = 4,
   parameter int unsigned rec_width_p   = 256,
   parameter int unsigned init_cycles_p = 8,
   parameter int unsigned drain_max_p   = 1024,
   parameter int unsigned wdog_max_p    = 65535,
   localparam int unsigned id_width_lp  = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              freeze_i,
   input  logic [31:0]                       instr_cap_i,
   input  logic [num_core_p-1:0]             v_i,
   input  logic [num_core_p*rec_width_p-1:0] rec_i,
   output logic [num_core_p-1:0]             yumi_o,
   output logic                              v_o,
   output logic [rec_width_p-1:0]            rec_o,
   output logic [id_width_lp-1:0]            core_id_o,
   input  logic                              ready_i,
   input  logic                              fail_i,
   output logic [num_core_p-1:0]             core_finish_o,
   output logic                              done_o,
   output logic                              pass_o,
   output logic                              fail_o
);

   bp_cosim_sched_state_e  state_q, state_d;
   logic [31:0]            init_cnt_q, init_cnt_d;
   logic [31:0]            drain_cnt_q, drain_cnt_d;
   logic [31:0]            retire_q [num_core_p];
   logic [31:0]            retire_d [num_core_p];
   logic [num_core_p-1:0]  finish_q, finish_d;
   logic                   fail_q, fail_d;
   logic [num_core_p-1:0]  masked_v;
   logic [id_width_lp-1:0] grant_id;
   logic                   arb_v;
   logic                   wdog_trip;

   // Reset gates requests combinationally so in-flight records are never acknowledged.
   always_comb begin
      masked_v = '0;
      unique case (state_q)
         e_run:   masked_v = v_i & ~finish_q;
         e_drain: masked_v = v_i;
         default: masked_v = '0;
      endcase
      if (reset_i) masked_v = '0;
   end

   bp_nonsynth_cosim_rr_arb #(
      .num_core_p(num_core_p)
   ) u_arb (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .v_i       (masked_v),
      .ready_i   (ready_i),
      .v_o       (arb_v),
      .grant_id_o(grant_id),
      .yumi_o    (yumi_o)
   );

   assign v_o       = arb_v;
   assign rec_o     = arb_v ? rec_i[grant_id*rec_width_p +: rec_width_p] : '0;
   assign core_id_o = arb_v ? grant_id : '0;

   always_comb begin
      finish_d = finish_q;
      for (int unsigned k = 0; k < num_core_p; k++) begin
         retire_d[k] = retire_q[k];
         if (yumi_o[k]) begin
            retire_d[k] = sat_inc32(retire_q[k]);
            if ((instr_cap_i != 32'd0) && (retire_d[k] == instr_cap_i)) finish_d[k] = 1'b1;
         end
      end
   end

`ifdef BP_COSIM_SCHED_WATCHDOG_EN
   logic [31:0] wdog_q, wdog_d;
   logic        wdog_stall;

   assign wdog_stall = (state_q == e_run) && (|v_i) && !(|yumi_o);
   assign wdog_trip  = wdog_stall && (wdog_q == 32'(wdog_max_p - 1));

   always_comb begin
      wdog_d = wdog_q;
      if (|yumi_o) wdog_d = '0;
      else if (wdog_stall) wdog_d = wdog_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) wdog_q <= '0;
      else         wdog_q <= wdog_d;
   end
`else
   assign wdog_trip = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      drain_cnt_d = drain_cnt_q;
      fail_d      = fail_q;
      unique case (state_q)
         e_init: begin
            if (freeze_i) begin
               init_cnt_d = '0;
            end else if (init_cnt_q == 32'(init_cycles_p - 1)) begin
               init_cnt_d = '0;
               state_d    = e_run;
            end else begin
               init_cnt_d = init_cnt_q + 32'd1;
            end
         end
         e_run: begin
            // Failure outranks a simultaneous last-core finish.
            if (fail_i || wdog_trip) begin
               state_d = e_done;
               fail_d  = 1'b1;
            end else if (&finish_q) begin
               state_d = e_drain;
            end
         end
         e_drain: begin
            drain_cnt_d = drain_cnt_q + 32'd1;
            if (fail_i) begin
               state_d = e_done;
               fail_d  = 1'b1;
            end else if (!(|v_i)) begin
               state_d = e_done;
            end else if (drain_cnt_q == 32'(drain_max_p - 1)) begin
               state_d = e_done;
               fail_d  = 1'b1;
            end
         end
         default: state_d = e_done;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= e_init;
         init_cnt_q  <= '0;
         drain_cnt_q <= '0;
         finish_q    <= '0;
         fail_q      <= 1'b0;
         for (int unsigned k = 0; k < num_core_p; k++) retire_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         finish_q    <= finish_d;
         fail_q      <= fail_d;
         for (int unsigned k = 0; k < num_core_p; k++) retire_q[k] <= retire_d[k];
      end
   end

   assign core_finish_o = finish_q;
   assign done_o        = (state_q == e_done);
   assign fail_o        = fail_q;
   assign pass_o        = done_o & ~fail_q;

endmodule

// File: tb/tb_bp_nonsynth_cosim_sched.sv
// Scoreboard bench for bp_nonsynth_cosim_sched: per-core record sources, expected-order queue.
module tb_bp_nonsynth_cosim_sched;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           reset_i, freeze_i, ready_i, fail_i;
   logic [31:0]    instr_cap_i;
   logic [N-1:0]   v_i;
   logic [N*W-1:0] rec_i;
   logic [N-1:0]   yumi_o, core_finish_o;
   logic           v_o, done_o, pass_o, fail_o;
   logic [W-1:0]   rec_o;
   logic [1:0]     core_id_o;

   always #5 clk = ~clk;

   bp_nonsynth_cosim_sched #(
      .num_core_p(N), .rec_width_p(W), .init_cycles_p(8), .drain_max_p(1024), .wdog_max_p(16)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .freeze_i(freeze_i), .instr_cap_i(instr_cap_i),
      .v_i(v_i), .rec_i(rec_i), .yumi_o(yumi_o), .v_o(v_o), .rec_o(rec_o),
      .core_id_o(core_id_o), .ready_i(ready_i), .fail_i(fail_i),
      .core_finish_o(core_finish_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o)
   );

   typedef struct packed {logic [1:0] id; logic [W-1:0] rec;} exp_t;

   int           n_cmp = 0;
   int           n_err = 0;
   int           avail [N];
   logic [11:0]  seq [N];
   exp_t         sb [$];
   exp_t         exp_e;
   logic [N-1:0] s_yumi;
   logic         s_v;
   logic [W-1:0] s_rec;
   logic [1:0]   s_id;

   function automatic logic [W-1:0] mk_rec(input int k, input logic [11:0] s);
      return {4'(k), s};
   endfunction

   task automatic drive_srcs();
      for (int k = 0; k < N; k++) begin
         v_i[k]         = (avail[k] > 0);
         rec_i[k*W +: W] = mk_rec(k, seq[k]);
      end
   endtask

   task automatic push_exp(input int k, input int s);
      sb.push_back({2'(k), mk_rec(k, 12'(s))});
   endtask

   // Sample outputs mid-cycle, then advance one edge and retire accepted records.
   task automatic tick();
      @(negedge clk);
      s_yumi = yumi_o; s_v = v_o; s_rec = rec_o; s_id = core_id_o;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
         if (s_yumi[k]) begin
            seq[k]   = seq[k] + 12'd1;
            avail[k] = avail[k] - 1;
         end
      end
      drive_srcs();
   endtask

   task automatic reset_init(input logic frz);
      for (int k = 0; k < N; k++) begin avail[k] = 0; seq[k] = '0; end
      sb.delete();
      ready_i = 1'b0; fail_i = 1'b0; instr_cap_i = '0;
      reset_i = 1'b1; freeze_i = frz;
      drive_srcs();
      repeat (2) @(posedge clk);
      #1 reset_i = 1'b0;
      if (!frz) begin
         repeat (8) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < N; k++) avail[k] = 1;
      ready_i = 1'b1; reset_i = 1'b1; freeze_i = 1'b0; fail_i = 1'b0; instr_cap_i = '0;
      drive_srcs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL reset_v_o got %b want 0", v_o); end
      n_cmp++; if (yumi_o !== '0) begin n_err++; $display("FAIL reset_yumi got %b want 0", yumi_o); end
      n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
      n_cmp++; if (pass_o !== 1'b0) begin n_err++; $display("FAIL reset_pass got %b want 0", pass_o); end
      n_cmp++; if (fail_o !== 1'b0) begin n_err++; $display("FAIL reset_fail got %b want 0", fail_o); end
      n_cmp++;
      if (core_finish_o !== '0) begin
         n_err++; $display("FAIL reset_finish got %b want 0", core_finish_o);
      end
      n_cmp++; if (rec_o !== '0) begin n_err++; $display("FAIL reset_rec got %h want 0", rec_o); end
      n_cmp++; if (core_id_o !== '0) begin n_err++; $display("FAIL reset_id got %0d want 0", core_id_o); end
   endtask

   task automatic test_freeze();
      int n;
      reset_init(1'b1);
      for (int k = 0; k < N; k++) avail[k] = 1;
      drive_srcs();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({v_o, done_o} !== 2'b00) begin
            n_err++; $display("FAIL freeze_hold cyc %0d got v=%b done=%b want 0 0", i, v_o, done_o);
         end
         @(posedge clk); #1;
      end
      // A one-cycle freeze pulse partway through must restart the init count.
      freeze_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 freeze_i = 1'b1;
      @(posedge clk);
      #1 freeze_i = 1'b0;
      n = 0;
      while (n < 50) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (v_o) break;
      end
      n_cmp++; if (n !== 8) begin n_err++; $display("FAIL freeze_release got %0d cycles want 8", n); end
   endtask

   task automatic test_round_robin();
      int cyc;
      reset_init(1'b0);
      ready_i = 1'b1;
      for (int k = 0; k < N; k++) avail[k] = 2;
      for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) push_exp(k, r);
      drive_srcs();
      cyc = 0;
      while (sb.size() != 0 && cyc < 20) begin
         tick(); cyc++;
         if (s_yumi != '0) begin
            exp_e = sb.pop_front();
            n_cmp++;
            if (!$onehot(s_yumi)) begin n_err++; $display("FAIL rr_onehot got %b", s_yumi); end
            n_cmp++;
            if ({s_id, s_rec} !== exp_e) begin
               n_err++; $display("FAIL rr_order got id=%0d rec=%h want id=%0d rec=%h",
                                 s_id, s_rec, exp_e.id, exp_e.rec);
            end
         end
      end
      n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL rr_cycles got %0d want 8", cyc); end
   endtask

   task automatic test_stall();
      reset_init(1'b0);
      ready_i = 1'b0;
      avail[2] = 1;
      push_exp(2, 0);
      push_exp(0, 0);
      drive_srcs();
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 1) begin avail[0] = 1; drive_srcs(); end
         n_cmp++;
         if (s_yumi !== '0 || s_v !== 1'b1 || s_rec !== mk_rec(2, 12'd0) || s_id !== 2'd2) begin
            n_err++; $display("FAIL stall_hold cyc %0d got yumi=%b v=%b id=%0d rec=%h want 0 1 2 %h",
                              i, s_yumi, s_v, s_id, s_rec, mk_rec(2, 12'd0));
         end
      end
      ready_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         exp_e = sb.pop_front();
         n_cmp++;
         if (s_yumi !== (4'b0001 << exp_e.id) || {s_id, s_rec} !== exp_e) begin
            n_err++; $display("FAIL stall_release %0d got yumi=%b id=%0d rec=%h want id=%0d rec=%h",
                              i, s_yumi, s_id, s_rec, exp_e.id, exp_e.rec);
         end
      end
      ready_i = 1'b0;
   endtask

   task automatic test_cap_drain();
      int cyc;
      reset_init(1'b0);
      instr_cap_i = 32'd3;
      ready_i = 1'b1;
      avail[0] = 3; avail[1] = 5; avail[2] = 3; avail[3] = 3;
      for (int r = 0; r < 3; r++) for (int k = 0; k < N; k++) push_exp(k, r);
      push_exp(1, 3);
      push_exp(1, 4);
      drive_srcs();
      cyc = 0;
      while (!done_o && cyc < 60) begin
         tick(); cyc++;
         if (s_yumi != '0) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL cap_extra got id=%0d rec=%h want none", s_id, s_rec);
            end else begin
               exp_e = sb.pop_front();
               if ({s_id, s_rec} !== exp_e) begin
                  n_err++; $display("FAIL cap_order got id=%0d rec=%h want id=%0d rec=%h",
                                    s_id, s_rec, exp_e.id, exp_e.rec);
               end
            end
         end
      end
      @(negedge clk);
      n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL cap_done got %b want 1", done_o); end
      n_cmp++; if (pass_o !== 1'b1) begin n_err++; $display("FAIL cap_pass got %b want 1", pass_o); end
      n_cmp++; if (fail_o !== 1'b0) begin n_err++; $display("FAIL cap_fail got %b want 0", fail_o); end
      n_cmp++;
      if (core_finish_o !== 4'hF) begin
         n_err++; $display("FAIL cap_finish got %b want 1111", core_finish_o);
      end
      n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL cap_left got %0d want 0", sb.size()); end
   endtask

   task automatic test_fail_race();
      reset_init(1'b0);
      instr_cap_i = 32'd1;
      ready_i = 1'b1;
      for (int k = 0; k < N; k++) begin avail[k] = 1; push_exp(k, 0); end
      drive_srcs();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) fail_i = 1'b1;
         tick();
         exp_e = sb.pop_front();
         n_cmp++;
         if (s_yumi !== (4'b0001 << i) || {s_id, s_rec} !== exp_e) begin
            n_err++; $display("FAIL race_grant %0d got yumi=%b id=%0d want id=%0d", i, s_yumi, s_id,
                              exp_e.id);
         end
      end
      fail_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL race_done got %b want 1", done_o); end
      n_cmp++; if (fail_o !== 1'b1) begin n_err++; $display("FAIL race_fail got %b want 1", fail_o); end
      n_cmp++; if (pass_o !== 1'b0) begin n_err++; $display("FAIL race_pass got %b want 0", pass_o); end
   endtask

   task automatic test_watchdog();
      logic exp_trip;
`ifdef BP_COSIM_SCHED_WATCHDOG_EN
      exp_trip = 1'b1;
`else
      exp_trip = 1'b0;
`endif
      reset_init(1'b0);
      ready_i = 1'b0;
      avail[0] = 1;
      drive_srcs();
      repeat (15) tick();
      @(negedge clk);
      n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL wdog_early got %b want 0", done_o); end
      tick();
      @(negedge clk);
      n_cmp++;
      if (fail_o !== exp_trip || done_o !== exp_trip) begin
         n_err++; $display("FAIL wdog_trip got fail=%b done=%b want %b", fail_o, done_o, exp_trip);
      end
   endtask

   task automatic test_reset_mid();
      reset_init(1'b0);
      ready_i = 1'b1;
      for (int k = 0; k < N; k++) avail[k] = 3;
      drive_srcs();
      tick();
      reset_i = 1'b1;
      @(negedge clk);
      n_cmp++; if (yumi_o !== '0) begin n_err++; $display("FAIL rstmid_yumi got %b want 0", yumi_o); end
      n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL rstmid_v got %b want 0", v_o); end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({done_o, fail_o, core_finish_o} !== '0) begin
         n_err++; $display("FAIL rstmid_state got done=%b fail=%b finish=%b want 0", done_o, fail_o,
                           core_finish_o);
      end
      #1 reset_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_freeze();
      test_round_robin();
      test_stall();
      test_cap_drain();
      test_fail_race();
      test_watchdog();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
